// File: rtl/mpr121_pkg.sv
// rtl/mpr121_pkg.sv - shared states, register map and read mux for the MPR121-style I2C target
package mpr121_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } state_t;

    localparam logic [7:0] REG_TOUCH_L      = 8'h00;
    localparam logic [7:0] REG_TOUCH_H      = 8'h01;
    localparam logic [7:0] REG_ECR          = 8'h5E;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h5A;

    function automatic logic [7:0] read_reg(input logic [7:0]  addr,
                                            input logic [11:0] touch,
                                            input logic [7:0]  ecr);
        logic [7:0] data;
        case (addr)
            REG_TOUCH_L: data = touch[7:0];
            REG_TOUCH_H: data = {4'h0, touch[11:8]};
            REG_ECR:     data = ecr;
            default:     data = 8'h00;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer, optional MPR121_TARGET_GLITCH_FILTER_EN filter, START/STOP/edge pulses
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_out,
    output logic start_out,
    output logic stop_out,
    output logic scl_rise_out,
    output logic scl_fall_out
);
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl;
    logic                   w_sda;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   r_start;
    logic                   r_stop;
    logic                   r_rise;
    logic                   r_fall;

    // Preset high so reset looks like an idle bus and never fakes a START.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef MPR121_TARGET_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist;
    logic [2:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[SYNC_STAGES-1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[SYNC_STAGES-1]};
            if (&r_scl_hist)       r_scl_filt <= 1'b1;
            else if (~|r_scl_hist) r_scl_filt <= 1'b0;
            if (&r_sda_hist)       r_sda_filt <= 1'b1;
            else if (~|r_sda_hist) r_sda_filt <= 1'b0;
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
            r_start <= w_scl & r_scl_d & r_sda_d & ~w_sda;
            r_stop  <= w_scl & r_scl_d & ~r_sda_d & w_sda;
            r_rise  <= w_scl & ~r_scl_d;
            r_fall  <= ~w_scl & r_scl_d;
        end
    end

    // r_sda_d is the line value from the cycle the edge was seen, aligned with the pulses.
    assign sda_out      = r_sda_d;
    assign start_out    = r_start;
    assign stop_out     = r_stop;
    assign scl_rise_out = r_rise;
    assign scl_fall_out = r_fall;

endmodule

// File: rtl/mpr121_target.sv
// rtl/mpr121_target.sv - MPR121-style I2C register target (touch status, ECR); MPR121_TARGET_GLITCH_FILTER_EN adds input filtering
module mpr121_target
    import mpr121_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [11:0] touch_status_in,
    output logic        wr_valid_out,
    output logic [7:0]  wr_addr_out,
    output logic [7:0]  wr_data_out,
    output logic        busy_out
);
    logic w_sda;
    logic w_start;
    logic w_stop;
    logic w_rise;
    logic w_fall;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .sda_out      (w_sda),
        .start_out    (w_start),
        .stop_out     (w_stop),
        .scl_rise_out (w_rise),
        .scl_fall_out (w_fall)
    );

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_rdy;
    logic        r_ack_drv;
    logic        r_rw;
    logic [7:0]  r_ptr;
    logic [7:0]  r_ecr;
    logic [11:0] r_snap;
    logic [7:0]  r_tx_shift;
    logic        r_tx_active;
    logic        r_last_bit;
    logic        r_busy;
    logic        r_wr_valid;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        w_ack_state;
    logic        w_rx_state;
    logic        w_addr_match;
    logic        w_sda_oe;

    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Byte-level decisions use r_byte_rdy, one cycle after the 8th rise has been shifted in.
    always_comb begin
        w_state_next = r_state;
        w_ack_state  = (r_state == ST_ADDR_ACK) || (r_state == ST_REG_ACK) || (r_state == ST_WR_ACK);
        w_rx_state   = (r_state == ST_ADDR) || (r_state == ST_REG) ||
                       (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA);
        w_sda_oe     = (w_ack_state && r_ack_drv) ||
                       ((r_state == ST_RD_DATA) && r_tx_active && !r_tx_shift[7]);
        if (w_stop) begin
            w_state_next = ST_IDLE;
        end else if (w_start) begin
            w_state_next = ST_ADDR;
        end else begin
            case (r_state)
                ST_ADDR:     if (r_byte_rdy) w_state_next = w_addr_match ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK: if (w_fall && r_ack_drv) w_state_next = r_rw ? ST_RD_DATA : ST_REG;
                ST_REG:      if (r_byte_rdy) w_state_next = ST_REG_ACK;
                ST_REG_ACK:  if (w_fall && r_ack_drv) w_state_next = ST_WR_DATA;
                ST_WR_DATA:  if (r_byte_rdy) w_state_next = ST_WR_ACK;
                ST_WR_ACK:   if (w_fall && r_ack_drv) w_state_next = ST_WR_DATA;
                ST_RD_DATA:  if (w_fall && r_last_bit) w_state_next = ST_RD_ACK;
                ST_RD_ACK:   if (w_rise) w_state_next = w_sda ? ST_IDLE : ST_RD_DATA;
                default:     w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_rdy  <= 1'b0;
            r_ack_drv   <= 1'b0;
            r_rw        <= 1'b0;
            r_ptr       <= '0;
            r_ecr       <= '0;
            r_snap      <= '0;
            r_tx_shift  <= '0;
            r_tx_active <= 1'b0;
            r_last_bit  <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            r_byte_rdy <= 1'b0;
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
            if (w_start || w_stop) begin
                r_bit_cnt   <= '0;
                r_ack_drv   <= 1'b0;
                r_tx_active <= 1'b0;
                r_last_bit  <= 1'b0;
            end else begin
                if (w_rise && w_rx_state) begin
                    r_shift    <= {r_shift[6:0], w_sda};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_byte_rdy <= (r_bit_cnt == 3'd7);
                end
                // First fall in an ACK state pulls SDA, the second releases it.
                if (w_fall && w_ack_state) r_ack_drv <= !r_ack_drv;
                case (r_state)
                    ST_ADDR: if (r_byte_rdy) begin
                        r_rw <= r_shift[0];
                        if (w_addr_match && r_shift[0]) r_snap <= touch_status_in;
                    end
                    ST_ADDR_ACK: if (w_fall && r_ack_drv && r_rw) begin
                        r_tx_active <= 1'b1;
                        r_tx_shift  <= read_reg(r_ptr, r_snap, r_ecr);
                    end
                    ST_REG: if (r_byte_rdy) r_ptr <= r_shift;
                    ST_WR_DATA: if (r_byte_rdy) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_ptr;
                        r_wr_data  <= r_shift;
                        r_ptr      <= r_ptr + 8'd1;
                        if (r_ptr == REG_ECR) r_ecr <= r_shift;
                    end
                    ST_RD_DATA: begin
                        if (r_byte_rdy) begin
                            r_last_bit <= 1'b1;
                        end else if (w_fall) begin
                            if (r_last_bit) begin
                                r_tx_active <= 1'b0;
                                r_last_bit  <= 1'b0;
                            end else if (!r_tx_active) begin
                                r_tx_active <= 1'b1;
                                r_tx_shift  <= read_reg(r_ptr, r_snap, r_ecr);
                            end else begin
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: if (w_rise && !w_sda) begin
                        r_ptr     <= r_ptr + 8'd1;
                        r_bit_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe_out   = w_sda_oe;
    assign busy_out     = r_busy;
    assign wr_valid_out = r_wr_valid;
    assign wr_addr_out  = r_wr_addr;
    assign wr_data_out  = r_wr_data;

endmodule

// File: tb/tb_mpr121_target.sv
// tb/tb_mpr121_target.sv - scoreboard bench for mpr121_target driving an open-drain I2C master model
module tb_mpr121_target;
    import mpr121_pkg::*;

    localparam int Q = 20;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        scl_m  = 1'b1;
    logic        sda_m  = 1'b1;
    logic        sda_bus;
    logic [11:0] touch  = 12'h000;
    logic        sda_oe_out;
    logic        wr_valid_out;
    logic [7:0]  wr_addr_out;
    logic [7:0]  wr_data_out;
    logic        busy_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] obs_mem [0:63];
    int          obs_wr = 0;
    int          obs_rd = 0;
    int          oe_cnt = 0;

    assign sda_bus = sda_m & ~sda_oe_out;

    always #5 clk_in = ~clk_in;

    mpr121_target #(
        .DEV_ADDR    (7'h5A),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .scl_in          (scl_m),
        .sda_in          (sda_bus),
        .sda_oe_out      (sda_oe_out),
        .touch_status_in (touch),
        .wr_valid_out    (wr_valid_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out)
    );

    always @(negedge clk_in) begin
        if (wr_valid_out) begin
            if (obs_wr < 64) obs_mem[obs_wr] = {wr_addr_out, wr_data_out};
            obs_wr = obs_wr + 1;
        end
        if (sda_oe_out) oe_cnt = oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic q_wait(input int n);
        repeat (n * Q) @(negedge clk_in);
    endtask

    task automatic i2c_start;
        sda_m = 1'b0; q_wait(2); scl_m = 1'b0; q_wait(1);
    endtask

    task automatic i2c_rstart;
        sda_m = 1'b1; q_wait(1); scl_m = 1'b1; q_wait(1);
        sda_m = 1'b0; q_wait(1); scl_m = 1'b0; q_wait(1);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; q_wait(1); scl_m = 1'b1; q_wait(1); sda_m = 1'b1; q_wait(2);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; q_wait(1); scl_m = 1'b1; q_wait(2); scl_m = 1'b0; q_wait(1);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; q_wait(1); scl_m = 1'b1; q_wait(1);
        b = sda_bus; q_wait(1); scl_m = 1'b0; q_wait(1);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = !b;
    endtask

    task automatic rd_check(input logic ack, input string tag);
        logic       b;
        logic [7:0] d;
        logic [7:0] e;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(!ack);
        e = exp_rd.pop_front();
        chk(tag, d, e);
    endtask

    task automatic drain_wr(input string tag);
        logic [15:0] e;
        chk({tag, "_cnt"}, obs_wr - obs_rd, exp_wr.size());
        while (obs_rd < obs_wr && obs_rd < 64 && exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            chk({tag, "_addr"}, obs_mem[obs_rd][15:8], e[15:8]);
            chk({tag, "_data"}, obs_mem[obs_rd][7:0], e[7:0]);
            obs_rd++;
        end
        obs_rd = obs_wr;
        exp_wr.delete();
    endtask

    task automatic set_ptr_read(input logic [7:0] ptr, input string tag);
        logic ack;
        i2c_start;
        put_byte(8'hB4, ack); chk({tag, "_ackw"}, ack, 1'b1);
        put_byte(ptr, ack);   chk({tag, "_ackr"}, ack, 1'b1);
        i2c_rstart;
        put_byte(8'hB5, ack); chk({tag, "_ackrd"}, ack, 1'b1);
    endtask

    initial begin
        logic ack;
        logic b;
        int   oe_before;

        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_oe", sda_oe_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_wr_valid", wr_valid_out, 1'b0);
        chk("rst_wr_addr", wr_addr_out, 8'h00);
        chk("rst_wr_data", wr_data_out, 8'h00);
        chk("rst_state", dut.r_state, ST_IDLE);
        q_wait(2);

        // ECR write, then read back across 0x5D/0x5E
        i2c_start;
        chk("busy_start", busy_out, 1'b1);
        put_byte(8'hB4, ack); chk("ecr_ack_addr", ack, 1'b1);
        put_byte(8'h5E, ack); chk("ecr_ack_reg", ack, 1'b1);
        exp_wr.push_back({8'h5E, 8'h8F});
        put_byte(8'h8F, ack); chk("ecr_ack_data", ack, 1'b1);
        i2c_stop;
        chk("busy_stop", busy_out, 1'b0);
        drain_wr("ecr_wr");
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h8F);
        set_ptr_read(8'h5D, "ecr_rd");
        rd_check(1'b1, "rd_5d");
        rd_check(1'b0, "rd_ecr");
        i2c_stop;
        drain_wr("ecr_rd_nowr");

        // touch read with a live change between bytes
        touch = 12'hA53;
        exp_rd.push_back(8'h53);
        exp_rd.push_back(8'h0A);
        set_ptr_read(8'h00, "tch");
        rd_check(1'b1, "rd_touch_l");
        touch = 12'h001;
        rd_check(1'b0, "rd_touch_h_snap");
        chk("nack_idle", dut.r_state, ST_IDLE);
        chk("nack_oe", sda_oe_out, 1'b0);
        i2c_stop;

        // wrong address
        oe_before = oe_cnt;
        i2c_start;
        put_byte(8'hB6, ack); chk("bad_addr_nack", ack, 1'b0);
        put_byte(8'h00, ack); chk("bad_addr_nack2", ack, 1'b0);
        chk("bad_addr_busy", busy_out, 1'b1);
        i2c_stop;
        chk("bad_addr_oe_cycles", oe_cnt - oe_before, 0);
        chk("bad_addr_busy_stop", busy_out, 1'b0);
        drain_wr("bad_addr");

        // pointer wrap
        i2c_start;
        put_byte(8'hB4, ack); chk("wrap_ack_addr", ack, 1'b1);
        put_byte(8'hFF, ack); chk("wrap_ack_reg", ack, 1'b1);
        exp_wr.push_back({8'hFF, 8'h11});
        put_byte(8'h11, ack); chk("wrap_ack_d0", ack, 1'b1);
        exp_wr.push_back({8'h00, 8'h22});
        put_byte(8'h22, ack); chk("wrap_ack_d1", ack, 1'b1);
        i2c_stop;
        drain_wr("wrap");

        // STOP after 4 bits of a data byte
        i2c_start;
        put_byte(8'hB4, ack); chk("part_ack_addr", ack, 1'b1);
        put_byte(8'h10, ack); chk("part_ack_reg", ack, 1'b1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        i2c_stop;
        drain_wr("partial");
        chk("part_state", dut.r_state, ST_IDLE);
        chk("part_oe", sda_oe_out, 1'b0);

        // reset while the target drives a 0 in RD_DATA
        touch = 12'h001;
        set_ptr_read(8'h00, "rst_rd");
        for (int i = 0; i < 3; i++) begin
            get_bit(b);
            chk("rst_rd_bit", b, 1'b0);
        end
        chk("rst_rd_driving", sda_oe_out, 1'b1);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_mid_oe", sda_oe_out, 1'b0);
        chk("rst_mid_state", dut.r_state, ST_IDLE);
        chk("rst_mid_busy", busy_out, 1'b0);
        rst_in = 1'b0;
        q_wait(1);
        i2c_stop;
        drain_wr("rst_mid");

        // ECR cleared by reset
        exp_rd.push_back(8'h00);
        set_ptr_read(8'h5E, "ecr_clr");
        rd_check(1'b0, "rd_ecr_after_rst");
        i2c_stop;

        chk("rd_q_empty", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mpr121_target.md
MPR121_TARGET -- requirements
Module: mpr121_target

Interface
REQ-001 The module SHALL have parameter DEV_ADDR, default 7'h5A, meaning the 7-bit I2C target address it responds to.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on scl_in and sda_in (minimum 2).
REQ-003 clk_in  input  1  system clock (100 MHz); one clock; all logic on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 scl_in  input  1  I2C clock as seen on the bus pin; asynchronous.
REQ-006 sda_in  input  1  I2C data as seen on the bus pin; asynchronous.
REQ-007 sda_oe_out  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 touch_status_in  input  12  live electrode status, bit n = electrode n touched.
REQ-009 wr_valid_out  output  1  one-cycle strobe: a write data byte was accepted.
REQ-010 wr_addr_out  output  8  register address of the accepted write byte.
REQ-011 wr_data_out  output  8  value of the accepted write byte.
REQ-012 busy_out  output  1  high from a START until the next STOP.

Function
REQ-013 Bus condition detection SHALL use synchronized lines: START = SDA falls while SCL high; STOP = SDA rises while SCL high; edges are detected one cycle after the synchronizer output changes.
REQ-014 FSM states SHALL be IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-015 Bits SHALL be sampled on the SCL rising edge, MSB first, using an 8-bit shift register and a 3-bit bit counter.
REQ-016 Any START, including a repeated START, SHALL go to ADDR with the bit counter cleared; any STOP SHALL go to IDLE and release SDA.
REQ-017 In ADDR, when the received address matches DEV_ADDR, the FSM SHALL go to ADDR_ACK; on a mismatch it SHALL return to IDLE without driving SDA.
REQ-018 From ADDR_ACK, R/W=0 SHALL lead to REG and R/W=1 SHALL lead to RD_DATA.
REQ-019 During an ACK state, sda_oe_out SHALL assert on the SCL falling edge that ends bit 8 and release on the next SCL falling edge.
REQ-020 REG SHALL load the 8-bit register pointer and then go to REG_ACK, which always ACKs and then goes to WR_DATA.
REQ-021 Each WR_DATA byte SHALL be ACKed; wr_valid_out SHALL pulse one cycle after the 8th SCL rise, with wr_addr_out = pointer; the pointer SHALL then increment, mod 256.
REQ-022 A write to 0x5E (ECR) SHALL update the internal ECR register.
REQ-023 Read map: 0x00 -> touch[7:0]; 0x01 -> {4'h0, touch[11:8]}; 0x5E -> ECR; all other addresses -> 8'h00.
REQ-024 touch_status_in SHALL be captured into a snapshot at the ADDR_ACK of a read, so that bytes 0x00 and 0x01 of one transaction are coherent.
REQ-025 In RD_DATA, each bit SHALL be placed on SDA (drive low for 0, release for 1) within 2 cycles of the SCL falling edge and held until the next falling edge.
REQ-026 The first read bit SHALL be presented on the falling edge that ends the address ACK.
REQ-027 In RD_ACK, the target SHALL release SDA.
REQ-028 On master ACK (SDA=0), the pointer SHALL increment and the FSM SHALL go to RD_DATA; on NACK it SHALL go to IDLE.
REQ-029 A START or STOP in any state, including mid-byte, SHALL take priority over bit processing in the same cycle.
REQ-030 wr_valid_out SHALL NOT pulse for a partial byte.

Reset
REQ-031 rst_in SHALL return the FSM to IDLE and clear sda_oe_out, busy_out, wr_valid_out, wr_addr_out, wr_data_out, the pointer, the snapshot and ECR to 0.
REQ-032 rst_in SHALL preset the synchronizers to 1 (bus idle).
REQ-033 A reset asserted mid-transaction SHALL release SDA in the cycle after rst_in is sampled.

Configuration
REQ-034 With MPR121_TARGET_GLITCH_FILTER_EN defined, each synchronized line SHALL pass a 3-cycle stability filter (it changes only after 3 equal consecutive samples), adding 3 cycles of detection latency.
REQ-035 Without MPR121_TARGET_GLITCH_FILTER_EN, there SHALL be no filter and no added latency.

Structure
REQ-036 A shared package mpr121_pkg SHALL hold the FSM state enum, the register addresses (TOUCH_L=8'h00, TOUCH_H=8'h01, ECR=8'h5E) and the default device address.
REQ-037 One sub-module, i2c_bus_sync, SHALL hold the synchronizer, the optional filter and the START/STOP/SCL-edge detection.

Verification
REQ-038 Write 0x5A+W, reg 0x5E, data 0x8F, STOP -> three ACKs, one wr_valid_out with addr 0x5E / data 0x8F, and a later read of 0x5E returns 0x8F.
REQ-039 touch_status_in=12'hA53; write reg 0x00, repeated START, 0x5A+R, read 2 bytes (ACK, NACK) -> bytes 0x53 then 0x0A, then IDLE.
REQ-040 touch_status_in changes from 12'hA53 to 12'h001 between byte 1 and byte 2 of the read -> the second byte is still 0x0A.
REQ-041 Address 0x5B -> no ACK, sda_oe_out stays 0 for the whole transaction, busy_out stays high until STOP.
REQ-042 Write with pointer 0xFF and two data bytes -> wr_addr_out is 0xFF then 0x00.
REQ-043 STOP after 4 bits of a data byte, or rst_in during RD_DATA -> no wr_valid_out, SDA released, FSM in IDLE.
